// File: rtl/chorus_mix_fsm_if.sv
// Sample handshake bundle between the delay buffer, the mixer and the DAC side.
// The master drives dry/wet samples and controls; the slave returns the mix.
interface chorus_mix_fsm_if #(
   parameter int PKT_WIDTH  = 16,
   parameter int GAIN_WIDTH = 8
);
   logic signed [PKT_WIDTH-1:0] dry_i;
   logic                        dryChanged_i;
   logic signed [PKT_WIDTH-1:0] wet_i;
   logic                        wetChanged_i;
   logic [GAIN_WIDTH-1:0]       mix_i;
   logic                        bypass_i;
   logic signed [PKT_WIDTH-1:0] mix_o;
   logic                        mixChanged_o;
   logic                        timeoutErr_o;
   logic                        seqErr_o;

   modport master (
      output dry_i, dryChanged_i, wet_i, wetChanged_i,
      output mix_i, bypass_i,
      input  mix_o, mixChanged_o, timeoutErr_o, seqErr_o
   );

   modport slave (
      input  dry_i, dryChanged_i, wet_i, wetChanged_i,
      input  mix_i, bypass_i,
      output mix_o, mixChanged_o, timeoutErr_o, seqErr_o
   );
endinterface

// File: rtl/chorus_mix_fsm.sv
// Wet/dry crossfade stage behind the chorus delay buffer.
// Pairs each dry sample with its delayed twin, mixes, rounds, saturates.
module chorus_mix_fsm #(
   parameter int PKT_WIDTH  = 16,
   parameter int GAIN_WIDTH = 8,
   parameter int TIMEOUT    = 15
) (
   input logic             clk,
   input logic             rst_n,
   chorus_mix_fsm_if.slave bus
);
   localparam int ACC_W = PKT_WIDTH + GAIN_WIDTH + 2;
   localparam logic [GAIN_WIDTH:0] FULL =
      {1'b1, {GAIN_WIDTH{1'b0}}};
   localparam logic signed [ACC_W-1:0] RND =
      ACC_W'(2 ** (GAIN_WIDTH - 1));
   localparam logic signed [ACC_W-1:0] SMAX =
      ACC_W'((2 ** (PKT_WIDTH - 1)) - 1);
   localparam logic signed [ACC_W-1:0] SMIN = ~SMAX;
   localparam logic [PKT_WIDTH-1:0] PMAX = SMAX[PKT_WIDTH-1:0];
   localparam logic [PKT_WIDTH-1:0] PMIN = SMIN[PKT_WIDTH-1:0];
   localparam logic [7:0] TMO = 8'(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE,
      WAIT_WET,
      MIX,
      OUTPUT
   } state_t;

   state_t                      r_state;
   logic signed [PKT_WIDTH-1:0] r_dry;
   logic signed [PKT_WIDTH-1:0] r_wet;
   logic [GAIN_WIDTH-1:0]       r_gain;
   logic                        r_byp;
   logic [7:0]                  r_cnt;
   logic signed [PKT_WIDTH-1:0] r_mix;
   logic                        r_to;
   logic                        r_seq;

   logic [GAIN_WIDTH:0]         w_gw;
   logic [GAIN_WIDTH:0]         w_gd;
   logic signed [ACC_W-1:0]     w_dry_x;
   logic signed [ACC_W-1:0]     w_wet_x;
   logic signed [ACC_W-1:0]     w_gw_x;
   logic signed [ACC_W-1:0]     w_gd_x;
   logic signed [ACC_W-1:0]     w_acc;
   logic signed [ACC_W-1:0]     w_sh;
   logic signed [PKT_WIDTH-1:0] w_res;

   assign w_gw = {1'b0, r_gain};
   assign w_gd = FULL - w_gw;
   assign w_dry_x = {{(ACC_W-PKT_WIDTH){r_dry[PKT_WIDTH-1]}}, r_dry};
   assign w_wet_x = {{(ACC_W-PKT_WIDTH){r_wet[PKT_WIDTH-1]}}, r_wet};
   assign w_gw_x = {{(ACC_W-GAIN_WIDTH-1){1'b0}}, w_gw};
   assign w_gd_x = {{(ACC_W-GAIN_WIDTH-1){1'b0}}, w_gd};
   assign w_acc = w_dry_x * w_gd_x + w_wet_x * w_gw_x + RND;
   assign w_sh = w_acc >>> GAIN_WIDTH;

   // Bypass passes dry untouched; otherwise clamp the rounded mix.
   always_comb begin
      w_res = w_sh[PKT_WIDTH-1:0];
      if (r_byp) begin
         w_res = r_dry;
      end else if (w_sh > SMAX) begin
         w_res = PMAX;
      end else if (w_sh < SMIN) begin
         w_res = PMIN;
      end
   end

   // Sample sequencer: capture, wait for wet, mix, strobe out.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_dry   <= '0;
         r_wet   <= '0;
         r_gain  <= '0;
         r_byp   <= 1'b0;
         r_cnt   <= '0;
         r_mix   <= '0;
         r_to    <= 1'b0;
         r_seq   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.dryChanged_i) begin
                  r_dry   <= bus.dry_i;
                  r_gain  <= bus.mix_i;
                  r_byp   <= bus.bypass_i;
                  r_cnt   <= '0;
                  r_state <= WAIT_WET;
               end else if (bus.wetChanged_i) begin
                  r_seq <= 1'b1;
               end
            end
            WAIT_WET: begin
               if (bus.wetChanged_i) begin
                  r_wet   <= bus.wet_i;
                  r_state <= MIX;
               end else if (r_cnt == TMO) begin
                  r_to    <= 1'b1;
                  r_byp   <= 1'b1;
                  r_state <= MIX;
               end else begin
                  r_cnt <= r_cnt + 8'd1;
               end
               if (bus.dryChanged_i) begin
                  r_seq <= 1'b1;
               end
            end
            MIX: begin
               r_mix   <= w_res;
               r_state <= OUTPUT;
               if (bus.dryChanged_i) begin
                  r_seq <= 1'b1;
               end
            end
            OUTPUT: begin
               if (bus.dryChanged_i) begin
                  r_dry   <= bus.dry_i;
                  r_gain  <= bus.mix_i;
                  r_byp   <= bus.bypass_i;
                  r_cnt   <= '0;
                  r_state <= WAIT_WET;
               end else begin
                  r_state <= IDLE;
               end
               if (bus.wetChanged_i) begin
                  r_seq <= 1'b1;
               end
            end
            default: begin
               r_state <= IDLE;
               r_seq   <= 1'b1;
            end
         endcase
      end
   end

   assign bus.mix_o        = r_mix;
   assign bus.mixChanged_o = (r_state == OUTPUT);
   assign bus.timeoutErr_o = r_to;
   assign bus.seqErr_o     = r_seq;
endmodule

// File: tb/tb_chorus_mix_fsm.sv
// Directed bench for the chorus wet/dry mixer.
// Vector table for the mix math, hand sequences for timing and errors.
module tb_chorus_mix_fsm;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   total = 0;
   int   bad = 0;

   always #5 clk = ~clk;

   chorus_mix_fsm_if #(.PKT_WIDTH(16), .GAIN_WIDTH(8)) bus ();

   chorus_mix_fsm #(
      .PKT_WIDTH(16),
      .GAIN_WIDTH(8),
      .TIMEOUT(15)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   typedef struct {
      int dry;
      int wet;
      int mix;
      bit byp;
      int wdly;
      bit b2b;
      int exp;
   } vec_t;

   vec_t tv [12];

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   // Drives one dry strobe and the wet strobe wdly cycles later
   // (0 = never), with an optional extra dry strobe at cycle extra.
   task automatic run(input string nm, input int dry, input int wet,
                      input int mix, input bit byp, input int wdly,
                      input bit b2b, input int extra,
                      input int exp, input int lat);
      int n;
      bit seen;
      if (!b2b) begin
         @(negedge clk);
         chk({nm, ".idle"}, int'(bus.mixChanged_o), 0);
      end
      bus.dry_i = 16'(dry);
      bus.mix_i = 8'(mix);
      bus.bypass_i = byp;
      bus.dryChanged_i = 1'b1;
      n = 0;
      seen = 1'b0;
      while (!seen && n < 40) begin
         @(negedge clk);
         n++;
         if (n == 1) begin
            bus.dry_i = 16'(dry + 11);
            bus.mix_i = 8'(255 - mix);
            bus.bypass_i = ~byp;
         end
         bus.dryChanged_i = (n == extra);
         if (n == extra) bus.dry_i = 16'(-dry - 7);
         bus.wetChanged_i = (n == wdly);
         if (n == wdly) bus.wet_i = 16'(wet);
         if (bus.mixChanged_o) seen = 1'b1;
      end
      chk({nm, ".lat"}, seen ? n : -1, lat);
      chk({nm, ".mix"}, int'($signed(bus.mix_o)), exp);
   endtask

   task automatic do_reset(input string nm);
      @(negedge clk);
      rst_n = 1'b0;
      bus.dryChanged_i = 1'b0;
      bus.wetChanged_i = 1'b0;
      @(negedge clk);
      @(negedge clk);
      chk({nm, ".mix"}, int'($signed(bus.mix_o)), 0);
      chk({nm, ".stb"}, int'(bus.mixChanged_o), 0);
      chk({nm, ".to"}, int'(bus.timeoutErr_o), 0);
      chk({nm, ".seq"}, int'(bus.seqErr_o), 0);
      rst_n = 1'b1;
   endtask

   initial begin
      int cnt;
      bus.dry_i = '0;
      bus.dryChanged_i = 1'b0;
      bus.wet_i = '0;
      bus.wetChanged_i = 1'b0;
      bus.mix_i = '0;
      bus.bypass_i = 1'b0;

      tv[0]  = '{1000, 3000, 0, 0, 4, 0, 1000};
      tv[1]  = '{1000, 3000, 128, 0, 4, 0, 2000};
      tv[2]  = '{1, 2, 128, 0, 4, 0, 2};
      tv[3]  = '{-32768, -32768, 200, 0, 4, 0, -32768};
      tv[4]  = '{32767, 32767, 255, 0, 4, 0, 32767};
      tv[5]  = '{-1, 0, 128, 0, 4, 0, 0};
      tv[6]  = '{0, -3, 255, 0, 4, 0, -3};
      tv[7]  = '{100, -100, 64, 0, 4, 0, 50};
      tv[8]  = '{1234, 5000, 128, 1, 4, 0, 1234};
      tv[9]  = '{-500, 700, 128, 0, 4, 1, 100};
      tv[10] = '{3210, -9999, 77, 1, 4, 1, 3210};
      tv[11] = '{256, 512, 192, 0, 4, 1, 448};

      do_reset("rst0");

      for (int i = 0; i < 12; i++) begin
         run($sformatf("vec%0d", i), tv[i].dry, tv[i].wet, tv[i].mix,
             tv[i].byp, tv[i].wdly, tv[i].b2b, 0, tv[i].exp,
             tv[i].wdly + 2);
      end
      chk("vec.to", int'(bus.timeoutErr_o), 0);
      chk("vec.seq", int'(bus.seqErr_o), 0);

      run("wet15", 1000, 3000, 128, 0, 16, 0, 0, 2000, 18);
      chk("wet15.to", int'(bus.timeoutErr_o), 0);

      run("tmo", 777, 5555, 128, 0, 0, 0, 0, 777, 18);
      chk("tmo.to", int'(bus.timeoutErr_o), 1);
      run("post_tmo", 10, 20, 128, 0, 4, 0, 0, 15, 6);
      chk("post_tmo.to", int'(bus.timeoutErr_o), 1);
      chk("post_tmo.seq", int'(bus.seqErr_o), 0);

      run("ovr", 400, 600, 128, 0, 4, 0, 2, 500, 6);
      chk("ovr.seq", int'(bus.seqErr_o), 1);
      cnt = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (bus.mixChanged_o) cnt++;
      end
      chk("ovr.nostb", cnt, 0);

      do_reset("rst1");
      @(negedge clk);
      bus.wet_i = 16'(42);
      bus.wetChanged_i = 1'b1;
      @(negedge clk);
      bus.wetChanged_i = 1'b0;
      @(negedge clk);
      chk("stray.seq", int'(bus.seqErr_o), 1);
      chk("stray.stb", int'(bus.mixChanged_o), 0);
      run("after_stray", 2000, -2000, 128, 0, 4, 0, 0, 0, 6);

      @(negedge clk);
      bus.dry_i = 16'(555);
      bus.dryChanged_i = 1'b1;
      @(negedge clk);
      bus.dryChanged_i = 1'b0;
      @(negedge clk);
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      chk("midrst.mix", int'($signed(bus.mix_o)), 0);
      chk("midrst.seq", int'(bus.seqErr_o), 0);
      chk("midrst.to", int'(bus.timeoutErr_o), 0);
      cnt = 0;
      for (int i = 0; i < 24; i++) begin
         @(negedge clk);
         if (bus.mixChanged_o) cnt++;
      end
      chk("midrst.nostb", cnt, 0);
      run("post_rst", 300, 100, 64, 0, 4, 0, 0, 250, 6);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
